// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper motor controller: FSM states,
// control-word field positions and status-word bit positions.
package stepper_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STEP_HI,
        STEP_LO,
        DONE
    } state_t;

    localparam int CW_EN        = 31;
    localparam int CW_DIR       = 30;
    localparam int CW_PERIOD_HI = 29;
    localparam int CW_PERIOD_LO = 20;
    localparam int CW_COUNT_HI  = 19;
    localparam int CW_COUNT_LO  = 0;

    localparam int ST_BUSY     = 31;
    localparam int ST_DONE     = 30;
    localparam int ST_ABORTED  = 29;
    localparam int ST_STEPS_HI = 19;
    localparam int ST_STEPS_LO = 0;

    // Low-phase length: the period is clamped so the low time is never
    // shorter than the high pulse.
    function automatic logic [31:0] low_ticks(input logic [9:0] period, input int pulse_ticks);
        logic [31:0] req_period;
        logic [31:0] min_period;
        req_period = {22'd0, period};
        min_period = 32'(2 * pulse_ticks);
        return ((req_period > min_period) ? req_period : min_period) - 32'(pulse_ticks);
    endfunction

endpackage

// File: rtl/stepper_tick_gen.sv
// Timing-tick prescaler: one-cycle tick every PRESCALE clocks while running.
module stepper_tick_gen #(
    parameter int PRESCALE = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tick = run && !clear && (count == LAST);

endmodule

// File: rtl/stepper_controller.sv
// Stepper motor controller: turns a memory-mapped command word into a
// timed step/dir/enable sequence and reports progress via a status word.
module stepper_controller
    import stepper_pkg::*;
#(
    parameter int PRESCALE    = 50,
    parameter int SETUP_TICKS = 2,
    parameter int PULSE_TICKS = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ctrl_word,
    output logic        step,
    output logic        dir,
    output logic        motor_en,
    output logic        busy,
    output logic [31:0] status_data,
    output logic        status_wEn
);

    state_t      state;
    logic [31:0] last_cmd;
    logic [19:0] steps;
    logic [31:0] tick_count;
    logic        done;
    logic        aborted;
    logic        tick;
    logic        accept;
    logic [19:0] cmd_count;
    logic [31:0] lo_len;

    assign busy      = (state != IDLE) && (state != DONE);
    assign accept    = !busy && ctrl_word[CW_EN] && (ctrl_word != last_cmd);
    assign cmd_count = last_cmd[CW_COUNT_HI:CW_COUNT_LO];
    assign lo_len    = low_ticks(last_cmd[CW_PERIOD_HI:CW_PERIOD_LO], PULSE_TICKS);

    stepper_tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .run  (busy),
        .clear(accept),
        .tick (tick)
    );

    always_comb begin
        status_data = '0;
        status_data[ST_BUSY]    = busy;
        status_data[ST_DONE]    = done;
        status_data[ST_ABORTED] = aborted;
        status_data[ST_STEPS_HI:ST_STEPS_LO] = steps;
    end

    // Clearing EN aborts any run and outranks a step or run completing on
    // the same edge, so only one status write is ever issued per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            step       <= 1'b0;
            dir        <= 1'b0;
            motor_en   <= 1'b0;
            status_wEn <= 1'b0;
            last_cmd   <= '0;
            steps      <= '0;
            tick_count <= '0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            status_wEn <= 1'b0;
            if (!ctrl_word[CW_EN]) begin
                last_cmd <= ctrl_word;
            end
            if (accept) begin
                last_cmd   <= ctrl_word;
                steps      <= '0;
                aborted    <= 1'b0;
                done       <= 1'b0;
                tick_count <= '0;
                dir        <= ctrl_word[CW_DIR];
                motor_en   <= 1'b1;
                state      <= SETUP;
            end else if (busy && !ctrl_word[CW_EN]) begin
                step       <= 1'b0;
                aborted    <= 1'b1;
                motor_en   <= 1'b0;
                status_wEn <= 1'b1;
                state      <= IDLE;
            end else if (busy && tick) begin
                tick_count <= tick_count + 1;
                case (state)
                    SETUP: begin
                        if (tick_count + 1 >= 32'(SETUP_TICKS)) begin
                            tick_count <= '0;
                            if (cmd_count == '0) begin
                                done       <= 1'b1;
                                motor_en   <= 1'b0;
                                status_wEn <= 1'b1;
                                state      <= DONE;
                            end else begin
                                step  <= 1'b1;
                                state <= STEP_HI;
                            end
                        end
                    end
                    STEP_HI: begin
                        if (tick_count + 1 >= 32'(PULSE_TICKS)) begin
                            tick_count <= '0;
                            step       <= 1'b0;
                            steps      <= steps + 20'd1;
                            status_wEn <= 1'b1;
                            state      <= STEP_LO;
                        end
                    end
                    STEP_LO: begin
                        if (tick_count + 1 >= lo_len) begin
                            tick_count <= '0;
                            if (steps == cmd_count) begin
                                done       <= 1'b1;
                                motor_en   <= 1'b0;
                                status_wEn <= 1'b1;
                                state      <= DONE;
                            end else begin
                                step  <= 1'b1;
                                state <= STEP_HI;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stepper_controller.sv
// Self-checking bench for stepper_controller: directed and random commands
// compared cycle by cycle against a timeline model of the motion profile.
module tb_stepper_controller;

    localparam int PRESCALE = 1;
    localparam int SETUP    = 2;
    localparam int PULSE    = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ctrl_word;
    logic        step;
    logic        dir;
    logic        motor_en;
    logic        busy;
    logic [31:0] status_data;
    logic        status_wEn;

    int n_checks = 0;
    int n_fail   = 0;

    stepper_controller #(
        .PRESCALE   (PRESCALE),
        .SETUP_TICKS(SETUP),
        .PULSE_TICKS(PULSE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ctrl_word  (ctrl_word),
        .step       (step),
        .dir        (dir),
        .motor_en   (motor_en),
        .busy       (busy),
        .status_data(status_data),
        .status_wEn (status_wEn)
    );

    always #5 clk = ~clk;

    // Cycle i counts from the first cycle after the accepting edge.
    // Returns {step, dir, motor_en, busy, status_wEn} and the status word.
    function automatic void model(input int i, input logic d, input int period, input int count,
                                  output logic [4:0] e_ctl, output logic [31:0] e_stat);
        int eff, endc, rel, k, ph, n;
        logic s, w;
        eff  = (period > 2 * PULSE) ? period : 2 * PULSE;
        endc = SETUP + count * eff;
        if (i < endc) begin
            rel = i - SETUP;
            if (rel < 0) begin
                s = 1'b0; w = 1'b0; n = 0;
            end else begin
                k = rel / eff;
                ph = rel % eff;
                s = (ph < PULSE);
                w = (ph == PULSE);
                n = k + ((ph >= PULSE) ? 1 : 0);
            end
            e_ctl  = {s, d, 1'b1, 1'b1, w};
            e_stat = 32'h8000_0000 | 32'(n);
        end else begin
            e_ctl  = {1'b0, d, 1'b0, 1'b0, (i == endc)};
            e_stat = 32'h4000_0000 | 32'(count);
        end
    endfunction

    task automatic run_cmd(input logic [31:0] word, input int abort_at, input int extra);
        logic d;
        int period, count, eff, endc, last, rises, wens;
        logic prev_step;
        logic [4:0]  e_ctl, got_ctl;
        logic [31:0] e_stat, abort_steps;
        d      = word[30];
        period = int'(word[29:20]);
        count  = int'(word[19:0]);
        eff    = (period > 2 * PULSE) ? period : 2 * PULSE;
        endc   = SETUP + count * eff;
        last   = (abort_at >= 0) ? abort_at + 2 : endc + 1 + extra;
        abort_steps = '0;
        rises = 0; wens = 0; prev_step = 1'b0;
        @(negedge clk);
        ctrl_word = word;
        @(posedge clk);
        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            if (abort_at >= 0 && i > abort_at) begin
                e_ctl  = {1'b0, d, 1'b0, 1'b0, (i == abort_at + 1)};
                e_stat = 32'h2000_0000 | abort_steps;
            end else begin
                model(i, d, period, count, e_ctl, e_stat);
            end
            got_ctl = {step, dir, motor_en, busy, status_wEn};
            n_checks++;
            if (got_ctl !== e_ctl) begin
                n_fail++;
                $display("[TB] FAIL ctl word=%h cycle=%0d got=%b expected=%b", word, i, got_ctl, e_ctl);
            end
            n_checks++;
            if (status_data !== e_stat) begin
                n_fail++;
                $display("[TB] FAIL status word=%h cycle=%0d got=%h expected=%h", word, i, status_data, e_stat);
            end
            if (step && !prev_step) rises++;
            if (status_wEn) wens++;
            prev_step = step;
            if (i == abort_at) begin
                abort_steps = {12'd0, e_stat[19:0]};
                ctrl_word = word & 32'h7FFF_FFFF;
            end
        end
        if (abort_at < 0) begin
            n_checks++;
            if (rises !== count || wens !== count + 1) begin
                n_fail++;
                $display("[TB] FAIL pulse_count word=%h got steps=%0d wEn=%0d expected steps=%0d wEn=%0d",
                         word, rises, wens, count, count + 1);
            end
        end
    endtask

    task automatic release_en();
        @(negedge clk);
        ctrl_word = ctrl_word & 32'h7FFF_FFFF;
        @(posedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ctrl_word = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({step, dir, motor_en, busy, status_wEn, status_data} !== 37'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_state got=%b/%h expected all zero",
                     {step, dir, motor_en, busy, status_wEn}, status_data);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({step, motor_en, busy, status_wEn, status_data} !== 36'd0) begin
            n_fail++;
            $display("[TB] FAIL post_reset_idle got=%b/%h expected all zero",
                     {step, motor_en, busy, status_wEn}, status_data);
        end
    endtask

    task automatic test_basic();
        $display("[TB] basic three-step run");
        run_cmd(32'hC0A0_0003, -1, 0);
        release_en();
    endtask

    task automatic test_clamp();
        $display("[TB] short period clamped");
        run_cmd(32'h8040_0002, -1, 0);
        release_en();
    endtask

    task automatic test_zero_count();
        $display("[TB] zero step count");
        run_cmd(32'hC0A0_0000, -1, 0);
        release_en();
    endtask

    task automatic test_abort();
        $display("[TB] abort mid-pulse and abort on pulse end");
        run_cmd(32'h80A0_0005, 23, 0);
        release_en();
        run_cmd(32'hC0A0_0004, 16, 0);
        release_en();
        run_cmd(32'h80C0_0002, 25, 0);
        release_en();
    endtask

    task automatic test_retrigger();
        $display("[TB] held command does not rerun, re-enable does");
        run_cmd(32'hC0A0_0002, -1, 20);
        release_en();
        run_cmd(32'hC0A0_0002, -1, 0);
        release_en();
    endtask

    task automatic test_random();
        logic [31:0] word;
        int period, count, eff, endc, abort_at;
        $display("[TB] random commands");
        for (int n = 0; n < 10; n++) begin
            period = int'($urandom_range(0, 30));
            count  = int'($urandom_range(0, 4));
            word   = {1'b1, 1'($urandom_range(0, 1)), 10'(period), 20'(count)};
            eff    = (period > 2 * PULSE) ? period : 2 * PULSE;
            endc   = SETUP + count * eff;
            abort_at = -1;
            if ($urandom_range(0, 2) == 0) abort_at = int'($urandom_range(0, 32'(endc - 1)));
            run_cmd(word, abort_at, 0);
            release_en();
        end
    endtask

    task automatic test_reset_midrun();
        $display("[TB] reset during step pulse");
        @(negedge clk);
        ctrl_word = 32'hC0A0_0003;
        @(posedge clk);
        repeat (4) @(negedge clk);
        n_checks++;
        if (step !== 1'b1 || motor_en !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_pulse got step=%b en=%b expected step=1 en=1", step, motor_en);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({step, dir, motor_en, busy, status_wEn, status_data} !== 37'd0) begin
            n_fail++;
            $display("[TB] FAIL async_reset got=%b/%h expected all zero",
                     {step, dir, motor_en, busy, status_wEn}, status_data);
        end
        ctrl_word = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        ctrl_word = '0;
        test_reset();
        test_basic();
        test_clamp();
        test_zero_count();
        test_abort();
        test_retrigger();
        test_random();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stepper_controller.md
STEPPER_CONTROLLER -- requirements
Module: stepper_controller

Interface
REQ-001 SHALL have parameter PRESCALE, default 50, meaning clk cycles per timing tick (1 us at 50 MHz); legal range >= 1.
REQ-002 SHALL have parameter SETUP_TICKS, default 2, meaning ticks between dir/motor_en assertion and the first step edge.
REQ-003 SHALL have parameter PULSE_TICKS, default 5, meaning step high width in ticks; legal range >= 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port ctrl_word, input, 32 bits: stepper control register (memory address 4095, already registered). Fields: [31] EN, [30] DIR, [29:20] PERIOD (ticks per step), [19:0] COUNT (steps).
REQ-007 SHALL have port step, output, 1 bit: step pulse to the motor driver.
REQ-008 SHALL have port dir, output, 1 bit: direction to the motor driver.
REQ-009 SHALL have port motor_en, output, 1 bit: active-high driver enable.
REQ-010 SHALL have port busy, output, 1 bit: high whenever state is not IDLE or DONE.
REQ-011 SHALL have port status_data, output, 32 bits: [31] busy, [30] done, [29] aborted, [28:20] zero, [19:0] steps completed.
REQ-012 SHALL have port status_wEn, output, 1 bit: single-cycle write strobe for status_data into an input address (4088).

Function
REQ-013 SHALL implement states IDLE, SETUP, STEP_HI, STEP_LO and DONE.
REQ-014 SHALL hold a last_cmd register, and in IDLE or DONE SHALL accept a command when EN=1 and ctrl_word != last_cmd: latch the word into last_cmd, clear the step counter and aborted, clear done, and enter SETUP on the next edge.
REQ-015 SHALL load last_cmd from ctrl_word on every cycle that EN=0, so that rewriting an identical command after clearing EN retriggers it.
REQ-016 SHALL drive dir and motor_en from the latched command from the SETUP entry cycle until the return to IDLE or DONE; dir SHALL never change while in STEP_HI or STEP_LO.
REQ-017 SHALL run the tick prescaler only outside IDLE/DONE, zero it at acceptance, and pulse tick once every PRESCALE cycles.
REQ-018 SHALL stay in SETUP for SETUP_TICKS ticks, then go to STEP_HI; if COUNT=0 it SHALL go straight to DONE with no step pulse.
REQ-019 SHALL drive step high only in STEP_HI, for exactly PULSE_TICKS ticks, then enter STEP_LO.
REQ-020 SHALL use an effective period of max(PERIOD, 2*PULSE_TICKS); STEP_LO SHALL last effective period minus PULSE_TICKS ticks.
REQ-021 SHALL increment steps completed (20-bit counter) on each STEP_HI->STEP_LO transition and pulse status_wEn in that cycle.
REQ-022 SHALL, at the end of STEP_LO, go to DONE when steps completed == COUNT, else go to STEP_HI.
REQ-023 SHALL, on entering DONE, set done, drop motor_en and pulse status_wEn; DONE SHALL behave as IDLE for acceptance.
REQ-024 SHALL, on EN=0 in any busy state, abort: step low the same edge, set aborted, drop motor_en, enter IDLE and pulse status_wEn; steps completed SHALL hold.
REQ-025 SHALL ignore ctrl_word changes with EN=1 while busy.
REQ-026 SHALL give abort priority over step completion when both occur in the same cycle, with a single status_wEn pulse.

Reset
REQ-027 SHALL on reset force state IDLE; step, dir, motor_en, busy and status_wEn to 0; status_data, last_cmd, counters and prescaler to 0.
REQ-028 SHALL, when reset is asserted mid-run, drop step and motor_en immediately and asynchronously.

Structure
REQ-029 SHALL take the state enum, ctrl_word field positions and status_data bit positions from shared package stepper_pkg.
REQ-030 SHALL instantiate the prescaler as sub-module stepper_tick_gen (inputs clk, reset, run, clear; output tick).

Verification (PRESCALE=1, SETUP_TICKS=2, PULSE_TICKS=5)
REQ-031 SHALL cover: ctrl_word=0xC0A00003 (EN, DIR=1, PERIOD=10, COUNT=3) -> dir=1, three step pulses 5 cycles high on a 10-cycle period, four status_wEn pulses, final status=0x40000003.
REQ-032 SHALL cover: PERIOD=4, COUNT=2 -> period clamped to 10 cycles.
REQ-033 SHALL cover: COUNT=0 with EN=1 -> DONE, with no step pulse and status=0x40000000.
REQ-034 SHALL cover: EN cleared after 2 of 5 steps -> step low next edge, status=0x20000002, IDLE.
REQ-035 SHALL cover: same word held after DONE -> no rerun; EN=0 for one cycle, then same word -> rerun.
REQ-036 SHALL cover: reset asserted during STEP_HI -> step and motor_en low without a clock edge, all outputs 0.
